tt_um_emern_scene_loader: RTL

TT_UM_EMERN_SCENE_LOADER -- requirements
Module: tt_um_emern_scene_loader

---
 rtl/tt_um_emern_scene_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/tt_um_emern_scene_loader.sv
// Scene loader: decodes a byte-stream of LOAD/MASK/BG/COMMIT packets into a shadow bank
// that is copied to the active bank at frame_start. Optional packet timeout: SCENE_LOADER_TIMEOUT_EN.
`ifndef N_POLY
`define N_POLY 4
`endif
`ifndef WCOLOR
`define WCOLOR 6
`endif
`ifndef WPX
`define WPX 7
`endif
`ifndef WPY
`define WPY 6
`endif

module tt_um_emern_scene_loader #(
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         frame_start,
    output logic [`N_POLY-1:0]           cmp_en,
    output logic [`WCOLOR-1:0]           background_color,
    output logic [`WCOLOR*`N_POLY-1:0]   poly_color,
    output logic [`WPX*`N_POLY-1:0]      v0_x,
    output logic [`WPX*`N_POLY-1:0]      v1_x,
    output logic [`WPX*`N_POLY-1:0]      v2_x,
    output logic [`WPY*`N_POLY-1:0]      v0_y,
    output logic [`WPY*`N_POLY-1:0]      v1_y,
    output logic [`WPY*`N_POLY-1:0]      v2_y,
    output logic                         swap_pending,
    output logic                         err
);
    localparam int NP = `N_POLY;
    localparam int WC = `WCOLOR;
    localparam int WX = `WPX;
    localparam int WY = `WPY;

    typedef struct packed {
        logic [WC-1:0] color;
        logic [WY-1:0] v2y;
        logic [WX-1:0] v2x;
        logic [WY-1:0] v1y;
        logic [WX-1:0] v1x;
        logic [WY-1:0] v0y;
        logic [WX-1:0] v0x;
    } poly_t;

    typedef struct packed {
        logic [NP-1:0]        cmp_en;
        logic [WC-1:0]        bg;
        poly_t [NP-1:0]       poly;
    } bank_t;

    typedef enum logic [1:0] {HDR, LOAD, BG, WAIT_SWAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          swap_pending_q, swap_pending_d;
    logic          in_ready_q, in_ready_d;
    bank_t         shadow_q, shadow_d;
    bank_t         active_q, active_d;
    logic          accept;

`ifdef SCENE_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        swap_pending_d = swap_pending_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        accept         = in_valid && in_ready_q;

        // A commit accepted this very cycle only sets pending, so it waits for the next frame_start.
        if (frame_start && swap_pending_q) begin
            active_d       = shadow_q;
            swap_pending_d = 1'b0;
        end

        case (state_q)
            HDR: begin
                if (accept) begin
                    case (in_data[7:6])
                        2'b00: begin
                            idx_d   = in_data[5:4];
                            cnt_d   = 3'd0;
                            state_d = LOAD;
                        end
                        2'b01: shadow_d.cmp_en = in_data[NP-1:0];
                        2'b10: state_d = BG;
                        default: begin
                            swap_pending_d = 1'b1;
                            state_d        = WAIT_SWAP;
                        end
                    endcase
                end
            end
            LOAD: begin
                if (accept) begin
                    case (cnt_q)
                        3'd0:    shadow_d.poly[idx_q].v0x   = in_data[WX-1:0];
                        3'd1:    shadow_d.poly[idx_q].v0y   = in_data[WY-1:0];
                        3'd2:    shadow_d.poly[idx_q].v1x   = in_data[WX-1:0];
                        3'd3:    shadow_d.poly[idx_q].v1y   = in_data[WY-1:0];
                        3'd4:    shadow_d.poly[idx_q].v2x   = in_data[WX-1:0];
                        3'd5:    shadow_d.poly[idx_q].v2y   = in_data[WY-1:0];
                        default: shadow_d.poly[idx_q].color = in_data[WC-1:0];
                    endcase
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        state_d = HDR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            BG: begin
                if (accept) begin
                    shadow_d.bg = in_data[WC-1:0];
                    state_d     = HDR;
                end
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase

`ifdef SCENE_LOADER_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
        tmo_inc = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        // Abandoning a stalled packet keeps the fields already written to shadow.
        if ((state_q == LOAD || state_q == BG) && !accept) begin
            if (tmo_inc == TW'(IDLE_TIMEOUT)) begin
                state_d = HDR;
                cnt_d   = 3'd0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_inc;
            end
        end
`endif

        in_ready_d = (state_d != WAIT_SWAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= HDR;
            cnt_q          <= 3'd0;
            idx_q          <= 2'd0;
            swap_pending_q <= 1'b0;
            in_ready_q     <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            swap_pending_q <= swap_pending_d;
            in_ready_q     <= in_ready_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

`ifdef SCENE_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready         = in_ready_q;
    assign swap_pending     = swap_pending_q;
    assign cmp_en           = active_q.cmp_en;
    assign background_color = active_q.bg;

    for (genvar i = 0; i < NP; i++) begin : g_pack
        assign poly_color[WC*i +: WC] = active_q.poly[i].color;
        assign v0_x[WX*i +: WX]       = active_q.poly[i].v0x;
        assign v1_x[WX*i +: WX]       = active_q.poly[i].v1x;
        assign v2_x[WX*i +: WX]       = active_q.poly[i].v2x;
        assign v0_y[WY*i +: WY]       = active_q.poly[i].v0y;
        assign v1_y[WY*i +: WY]       = active_q.poly[i].v1y;
        assign v2_y[WY*i +: WY]       = active_q.poly[i].v2y;
    end

endmodule
